// File: rtl/fx_chain_sequencer.sv
// ---------------------------------------------------------------------------
// fx_chain_sequencer
// Walks one audio sample through a chain of external effect stages. A sample
// accepted in IDLE is offered to each enabled stage in turn (index order). The
// sequencer waits for that stage's result, or bypasses the stage once its
// response window expires. The final word is then presented on o_data with a
// one-cycle o_valid strobe. Samples are never modified here; stages return
// full 16-bit words.
//
// Ports
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_valid, i_data     new sample strobe / sample (accepted only when idle)
//   i_enable            per-stage enable, captured when the sample is accepted
//   o_stage_valid       one-hot issue strobe to stage k
//   o_stage_data        current working sample presented to the issued stage
//   i_stage_valid       stage-k result strobe
//   i_stage_data        stage-k result in bits [16k+15:16k]
//   o_data, o_valid     processed sample and its one-cycle strobe
//   o_busy              high whenever the sequencer is not idle
//   o_drop              pulse: a sample arrived while busy and was discarded
//   o_timeout           pulse: a stage was bypassed because it never answered
// ---------------------------------------------------------------------------
module fx_chain_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic                         i_valid,
    input  logic signed [15:0]           i_data,
    input  logic [NUM_STAGES-1:0]        i_enable,
    output logic [NUM_STAGES-1:0]        o_stage_valid,
    output logic signed [15:0]           o_stage_data,
    input  logic [NUM_STAGES-1:0]        i_stage_valid,
    input  logic [16*NUM_STAGES-1:0]     i_stage_data,
    output logic signed [15:0]           o_data,
    output logic                         o_valid,
    output logic                         o_busy,
    output logic                         o_drop,
    output logic                         o_timeout
);

    localparam int IDX_W = $clog2(NUM_STAGES + 1);
    localparam logic [IDX_W-1:0] IDX_END    = IDX_W'(NUM_STAGES);
    localparam logic [7:0]       TIMER_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic signed [15:0]      work_q, work_d;
    logic [NUM_STAGES-1:0]   en_snap_q, en_snap_d;
    logic [7:0]              timer_q, timer_d;
    logic signed [15:0]      data_out_q, data_out_d;
    logic                    valid_out_q, valid_out_d;
    logic                    drop_q, drop_d;
    logic                    timeout_q, timeout_d;

    // Per-stage view of the current slot: enable bit, response strobe and data.
    logic [NUM_STAGES-1:0]   slot_hit;
    logic [NUM_STAGES-1:0]   slot_en;
    logic [NUM_STAGES-1:0]   slot_resp;
    logic [15:0]             slot_data [NUM_STAGES];

    genvar gi;
    generate
        for (gi = 0; gi < NUM_STAGES; gi++) begin : g_slot
            assign slot_hit[gi]      = (idx_q == IDX_W'(gi));
            assign slot_en[gi]       = slot_hit[gi] & en_snap_q[gi];
            assign slot_resp[gi]     = slot_hit[gi] & i_stage_valid[gi];
            assign slot_data[gi]     = i_stage_data[16*gi +: 16];
            assign o_stage_valid[gi] = (state_q == ISSUE) & slot_en[gi];
        end
    endgenerate

    // Result word of the stage currently waited on (zero when none selected).
    logic [15:0] resp_data;
    always_comb begin
        resp_data = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (slot_hit[k]) begin
                resp_data = slot_data[k];
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        work_d      = work_q;
        en_snap_d   = en_snap_q;
        timer_d     = timer_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        timeout_d   = 1'b0;
        // Anything offered while not idle is thrown away and flagged.
        drop_d      = i_valid && (state_q != IDLE);

        case (state_q)
            IDLE: begin
                if (i_valid) begin
                    work_d    = i_data;
                    en_snap_d = i_enable;
                    idx_d     = '0;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (idx_q == IDX_END) begin
                    // Output registers load here so the strobe lines up with DONE.
                    state_d     = DONE;
                    valid_out_d = 1'b1;
                    data_out_d  = work_q;
                end else if (|slot_en) begin
                    timer_d = '0;
                    state_d = WAIT;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            WAIT: begin
                // A response on the final timer cycle still beats the timeout.
                if (|slot_resp) begin
                    work_d  = resp_data;
                    idx_d   = idx_q + IDX_W'(1);
                    state_d = ISSUE;
                end else if (timer_q == TIMER_LAST) begin
                    idx_d     = idx_q + IDX_W'(1);
                    state_d   = ISSUE;
                    timeout_d = 1'b1;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            work_q      <= '0;
            en_snap_q   <= '0;
            timer_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            drop_q      <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            work_q      <= work_d;
            en_snap_q   <= en_snap_d;
            timer_q     <= timer_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            drop_q      <= drop_d;
            timeout_q   <= timeout_d;
        end
    end

    assign o_stage_data = work_q;
    assign o_data       = data_out_q;
    assign o_valid      = valid_out_q;
    assign o_busy       = (state_q != IDLE);
    assign o_drop       = drop_q;
    assign o_timeout    = timeout_q;

endmodule

// File: doc/fx_chain_sequencer.md
FX_CHAIN_SEQUENCER -- requirements
Module: fx_chain_sequencer

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 4: number of effect-stage slots in the chain, 1..8.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum WAIT cycles allowed per stage, 2..255.
REQ-003 SHALL have port i_clk, input, 1: single clock; all logic on the rising edge.
REQ-004 SHALL have port i_rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port i_valid, input, 1: new-sample strobe from the codec side.
REQ-006 SHALL have port i_data, input, 16 signed: incoming sample.
REQ-007 SHALL have port i_enable, input, NUM_STAGES: per-stage enable; bit k = stage k.
REQ-008 SHALL have port o_stage_valid, output, NUM_STAGES: one-hot issue strobe to stage k.
REQ-009 SHALL have port o_stage_data, output, 16 signed: sample presented to the issued stage.
REQ-010 SHALL have port i_stage_valid, input, NUM_STAGES: stage-k result strobe.
REQ-011 SHALL have port i_stage_data, input, 16*NUM_STAGES: stage-k result in bits [16k+15:16k].
REQ-012 SHALL have port o_data, output, 16 signed: processed sample.
REQ-013 SHALL have port o_valid, output, 1: one-cycle strobe marking o_data as new.
REQ-014 SHALL have port o_busy, output, 1: high whenever state is not IDLE.
REQ-015 SHALL have port o_drop, output, 1: one-cycle pulse, sample rejected.
REQ-016 SHALL have port o_timeout, output, 1: one-cycle pulse, stage bypassed on timeout.

Function
REQ-017 SHALL implement states IDLE, ISSUE, WAIT and DONE; registers: state, idx (0..NUM_STAGES), work (16 bits), en_snap (NUM_STAGES), timer (8 bits).
REQ-018 In IDLE with i_valid=1, SHALL latch work<=i_data, en_snap<=i_enable and idx<=0, then go to ISSUE.
REQ-019 In ISSUE with idx==NUM_STAGES, SHALL go to DONE.
REQ-020 In ISSUE with en_snap[idx]=0, SHALL set idx<=idx+1 and stay in ISSUE (one cycle per skipped stage).
REQ-021 In ISSUE with en_snap[idx]=1, SHALL assert o_stage_valid[idx] for that single cycle, set timer<=0 and go to WAIT.
REQ-022 o_stage_valid SHALL be zero in every other state and for every other bit.
REQ-023 o_stage_data SHALL equal work at all times.
REQ-024 In WAIT with i_stage_valid[idx]=1, SHALL set work<=i_stage_data slice idx and idx<=idx+1, then go to ISSUE.
REQ-025 In WAIT, i_stage_valid bits other than idx SHALL be ignored.
REQ-026 In WAIT with no response, SHALL increment timer each cycle.
REQ-027 In WAIT, when timer==TIMEOUT-1 with no response, SHALL leave work unchanged, set idx<=idx+1, go to ISSUE and pulse o_timeout in the following cycle.
REQ-028 If the response arrives in the same cycle as the timeout condition, the response SHALL win and no o_timeout SHALL be produced.
REQ-029 In DONE, SHALL assert o_valid for exactly one cycle with o_data=work, then go to IDLE.
REQ-030 o_data SHALL hold its last value between o_valid strobes.
REQ-031 SHALL accept i_valid only in IDLE.
REQ-032 i_valid in any other state SHALL be discarded, with o_drop pulsed in the next cycle; it SHALL change no other state.
REQ-033 Changes to i_enable after a sample is accepted SHALL NOT affect that sample (en_snap is used).
REQ-034 Latency from the i_valid cycle to the o_valid cycle SHALL be NUM_STAGES+2+sum(w_k), where w_k is the number of WAIT cycles spent on each enabled stage (1..TIMEOUT).
REQ-035 A late i_stage_valid from a timed-out stage SHALL be ignored.
REQ-036 Samples SHALL pass through unmodified (no arithmetic); stage data SHALL be taken as full 16-bit words.

Reset
REQ-037 i_rst=1 at a clock edge SHALL set state=IDLE, idx=0, work=0, en_snap=0, timer=0 and clear all outputs to 0.
REQ-038 Reset SHALL take precedence over every other input, including mid-WAIT or in DONE; no o_valid, o_drop or o_timeout SHALL follow a reset.

Verification (NUM_STAGES=4, TIMEOUT=8)
REQ-039 i_enable=4'b0000, i_data=0x1234 -> o_valid 6 cycles later, o_data=0x1234, o_stage_valid never asserted.
REQ-040 i_enable=4'b0101, i_data=0x1000; stage0 returns 0x0800 one cycle after its strobe; stage2 returns 0x0400 one cycle after its strobe -> o_stage_data=0x0800 at stage2's strobe, o_data=0x0400, latency 8.
REQ-041 i_enable=4'b0001, stage0 silent, i_data=0x7FFF -> exactly one o_timeout pulse, o_data=0x7FFF, latency 14; a stage0 strobe afterwards has no effect.
REQ-042 Second i_valid 2 cycles after an accepted one -> o_drop one cycle later, a single o_valid, first sample's result only.
REQ-043 i_rst asserted in WAIT -> all outputs 0 next cycle; a following sample completes with normal latency.
REQ-044 i_enable changed from 4'b0000 to 4'b1111 one cycle after acceptance -> no o_stage_valid, latency 6.
